// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer between the uart_rx byte receiver and the
// picorv32 native memory bus. Received bytes are queued in a DEPTH-entry FIFO
// and drained by the CPU through DATA/STATUS/CTRL registers; a level IRQ
// signals data at or above a threshold and/or a sticky overflow.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   in_valid   one-cycle byte strobe from uart_rx
//   in_data    received byte, qualified by in_valid
//   bus_cs     chip select (mem_valid & address decode)
//   bus_addr   word select: 0=DATA 1=STATUS 2=CTRL 3=reserved
//   bus_wstrb  byte write strobes, zero means read
//   bus_wdata  write data
//   bus_rdata  registered read data, valid while bus_ready is high
//   bus_ready  single-cycle access acknowledge
//   irq        registered level interrupt request
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        bus_cs,
  input  logic [1:0]  bus_addr,
  input  logic [3:0]  bus_wstrb,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic        irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam logic [31:0] RD_NO_DATA = 32'h0000_0100;

  // Elaboration guard on the supported FIFO geometry
  if (DEPTH < 2 || DEPTH > 128 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two in 2..128");
  end

  // Storage and state
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          overflow_q, overflow_d;
  logic          rx_ie_q, rx_ie_d;
  logic          ovf_ie_q, ovf_ie_d;
  logic [7:0]    thresh_q, thresh_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ready_q, ready_d;
  logic          irq_q, irq_d;

  // Per-cycle decode
  logic          acc;
  logic          is_wr;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic          flush;
  logic          ovf_clr;
  logic [7:0]    eff_thresh;
  logic [31:0]   rd_mux;

  // Write-data bits with no register behind them
  logic          unused_wdata;
  assign unused_wdata = ^{bus_wdata[31:16], bus_wdata[7:4]};

  // Access decode, FIFO bookkeeping, register updates and read mux
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rx_ie_d    = rx_ie_q;
    ovf_ie_d   = ovf_ie_q;
    thresh_d   = thresh_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    irq_d      = 1'b0;
    rd_mux     = 32'h0;

    // A held chip select is only accepted once per ready pulse
    acc     = bus_cs && !ready_q;
    is_wr   = |bus_wstrb;
    empty   = (count_q == '0);
    full    = (count_q == FULL_CNT);
    pop     = acc && (bus_addr == ADDR_DATA) && !is_wr && !empty;
    flush   = acc && (bus_addr == ADDR_STATUS) && bus_wstrb[0] && bus_wdata[3];
    ovf_clr = acc && (bus_addr == ADDR_STATUS) && bus_wstrb[0] && bus_wdata[2];
    // A pop in the same edge frees the slot the push needs
    push    = in_valid && (!full || pop) && !flush;
    drop    = in_valid && full && !pop && !flush;

    // Read mux sees pre-push, pre-pop state
    unique case (bus_addr)
      ADDR_DATA:   rd_mux = empty ? RD_NO_DATA : {24'h0, mem_q[rd_ptr_q]};
      ADDR_STATUS: rd_mux = {16'h0, 8'(count_q), 5'h0, overflow_q, full, empty};
      ADDR_CTRL:   rd_mux = {16'h0, thresh_q, 6'h0, ovf_ie_q, rx_ie_q};
      default:     rd_mux = 32'h0;
    endcase

    if (acc) begin
      ready_d = 1'b1;
      rdata_d = is_wr ? 32'h0 : rd_mux;
    end

    if (acc && (bus_addr == ADDR_CTRL)) begin
      if (bus_wstrb[0]) begin
        rx_ie_d  = bus_wdata[0];
        ovf_ie_d = bus_wdata[1];
      end
      if (bus_wstrb[1]) begin
        thresh_d = bus_wdata[15:8];
      end
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    // A fresh drop outranks a clear issued on the same edge
    if (ovf_clr) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end

    // Threshold 0 behaves as 1; evaluated on current state for one cycle of latency
    eff_thresh = (thresh_q == 8'd0) ? 8'd1 : thresh_q;
    irq_d = (rx_ie_q && ({1'b0, 8'(count_q)} >= {1'b0, eff_thresh}))
            || (ovf_ie_q && overflow_q);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rx_ie_q    <= 1'b0;
      ovf_ie_q   <= 1'b0;
      thresh_q   <= 8'd1;
      rdata_q    <= 32'h0;
      ready_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rx_ie_q    <= rx_ie_d;
      ovf_ie_q   <= ovf_ie_d;
      thresh_q   <= thresh_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      irq_q      <= irq_d;
    end
  end

  // FIFO storage, contents are don't-care until counted in
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign bus_rdata = rdata_q;
  assign bus_ready = ready_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed scenarios followed by randomized
// traffic, checked by a queue-based reference model and a scoreboard monitor.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h0;
  logic        bus_cs = 1'b0;
  logic [1:0]  bus_addr = 2'd0;
  logic [3:0]  bus_wstrb = 4'h0;
  logic [31:0] bus_wdata = 32'h0;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        irq;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .bus_cs    (bus_cs),
    .bus_addr  (bus_addr),
    .bus_wstrb (bus_wstrb),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .irq       (irq)
  );

  always #20 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [31:0] v;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_rd = 32'h0;

  // Reference model state
  bit [7:0] mq[$];
  bit       m_ovf   = 1'b0;
  bit       m_rxie  = 1'b0;
  bit       m_ovfie = 1'b0;
  bit [7:0] m_thr   = 8'd1;
  bit       m_rdy   = 1'b0;
  bit       m_irq   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, registers as plain variables
  initial begin
    int   thr_eff;
    bit   irq_n;
    bit   acc;
    bit   wr;
    bit   flushed;
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        m_ovf = 0; m_rxie = 0; m_ovfie = 0; m_thr = 8'd1;
        m_rdy = 0; m_irq = 0;
      end else begin
        thr_eff = (m_thr == 0) ? 1 : int'(m_thr);
        irq_n   = (m_rxie && mq.size() >= thr_eff) || (m_ovfie && m_ovf);
        acc     = bus_cs && !m_rdy;
        wr      = (bus_wstrb != 4'h0);
        flushed = 0;
        if (acc) begin
          e.chk = !wr;
          e.v   = 32'h0;
          case (bus_addr)
            2'd0: if (!wr) begin
              if (mq.size() == 0) e.v = 32'h0000_0100;
              else e.v = {24'h0, mq.pop_front()};
            end
            2'd1: begin
              if (!wr) e.v = {16'h0, 8'(mq.size()), 5'h0, m_ovf, mq.size() == DEPTH, mq.size() == 0};
              else if (bus_wstrb[0]) begin
                if (bus_wdata[2]) m_ovf = 0;
                if (bus_wdata[3]) begin mq.delete(); flushed = 1; end
              end
            end
            2'd2: begin
              if (!wr) e.v = {16'h0, m_thr, 6'h0, m_ovfie, m_rxie};
              if (bus_wstrb[0]) begin m_rxie = bus_wdata[0]; m_ovfie = bus_wdata[1]; end
              if (bus_wstrb[1]) m_thr = bus_wdata[15:8];
            end
            default: ;
          endcase
          sb.push_back(e);
        end
        if (in_valid && !flushed) begin
          if (mq.size() < DEPTH) mq.push_back(in_data);
          else m_ovf = 1;
        end
        m_rdy = acc;
        m_irq = irq_n;
      end
    end
  end

  // Monitor: per-cycle handshake/irq checks and scoreboard pops on bus_ready
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      check("bus_ready", {31'h0, bus_ready}, {31'h0, m_rdy});
      check("irq", {31'h0, irq}, {31'h0, m_irq});
      if (bus_ready === 1'b1) begin
        last_rd = bus_rdata;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_ready: got rdata %08h expected no access at %0t", bus_rdata, $time);
        end else begin
          e = sb.pop_front();
          if (e.chk) check("bus_rdata", bus_rdata, e.v);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic access(input logic [1:0] a, input logic [3:0] ws, input logic [31:0] wd);
    bus_cs    = 1'b1;
    bus_addr  = a;
    bus_wstrb = ws;
    bus_wdata = wd;
    cyc();
    bus_cs    = 1'b0;
    bus_wstrb = 4'h0;
    cyc();
  endtask

  task automatic read_expect(input string nm, input logic [1:0] a, input logic [31:0] v);
    access(a, 4'h0, 32'h0);
    check(nm, last_rd, v);
  endtask

  initial begin
    int pulses;
    int run;
    int max_run;

    // Reset state
    repeat (3) cyc();
    check("rst_rdata", bus_rdata, 32'h0);
    check("rst_ready", {31'h0, bus_ready}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rst = 1'b0;
    cyc();
    read_expect("rst_ctrl", 2'd2, 32'h0000_0100);

    // Ordering and empty read
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    read_expect("order_status", 2'd1, 32'h0000_0300);
    read_expect("order_d0", 2'd0, 32'h41);
    read_expect("order_d1", 2'd0, 32'h42);
    read_expect("order_d2", 2'd0, 32'h43);
    read_expect("order_empty", 2'd0, 32'h0000_0100);
    read_expect("order_status_e", 2'd1, 32'h0000_0001);

    // Full and overflow, W1C and flush
    for (int i = 0; i < 17; i++) push_byte(8'(8'h10 + i));
    read_expect("full_status", 2'd1, 32'h0000_1006);
    access(2'd1, 4'h1, 32'h4);
    read_expect("ovf_clear", 2'd1, 32'h0000_1002);
    access(2'd1, 4'h1, 32'h8);
    read_expect("flush", 2'd1, 32'h0000_0001);

    // Push and pop on the same edge at full
    for (int i = 0; i < 16; i++) push_byte(8'(8'h60 + i));
    in_valid = 1'b1;
    in_data  = 8'hEE;
    bus_cs = 1'b1; bus_addr = 2'd0; bus_wstrb = 4'h0;
    cyc();
    in_valid = 1'b0;
    bus_cs   = 1'b0;
    cyc();
    check("fullpop_head", last_rd, 32'h60);
    read_expect("fullpop_status", 2'd1, 32'h0000_1002);
    for (int i = 1; i < 16; i++) access(2'd0, 4'h0, 32'h0);
    read_expect("fullpop_tail", 2'd0, 32'hEE);

    // IRQ threshold
    access(2'd2, 4'h3, 32'h0000_0401);
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    cyc(); cyc();
    check("irq_below", {31'h0, irq}, 32'h0);
    push_byte(8'h04);
    @(negedge clk);
    check("irq_lat0", {31'h0, irq}, 32'h0);
    @(negedge clk);
    check("irq_set", {31'h0, irq}, 32'h1);
    cyc();
    access(2'd0, 4'h0, 32'h0);
    @(negedge clk);
    check("irq_drop", {31'h0, irq}, 32'h0);
    cyc();

    // Held chip select with 3 entries
    bus_cs = 1'b1; bus_addr = 2'd0; bus_wstrb = 4'h0;
    pulses = 0; run = 0; max_run = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_ready === 1'b1) begin
        pulses++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    bus_cs = 1'b0;
    cyc();
    check("held_pulses", 32'(pulses), 32'd2);
    check("held_maxrun", 32'(max_run), 32'd1);
    read_expect("held_status", 2'd1, 32'h0000_0100);

    // Reset in the same cycle as a DATA access
    push_byte(8'h05);
    access(2'd2, 4'h3, 32'h0000_0101);
    cyc();
    rst = 1'b1;
    bus_cs = 1'b1; bus_addr = 2'd0; bus_wstrb = 4'h0;
    cyc();
    rst = 1'b0;
    bus_cs = 1'b0;
    @(negedge clk);
    check("rstacc_ready", {31'h0, bus_ready}, 32'h0);
    check("rstacc_irq", {31'h0, irq}, 32'h0);
    cyc();
    read_expect("rstacc_status", 2'd1, 32'h0000_0001);
    read_expect("rstacc_ctrl", 2'd2, 32'h0000_0100);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom % 700) == 0;
      in_valid  = ($urandom % 3) == 0;
      in_data   = 8'($urandom);
      bus_cs    = ($urandom % 2) == 0;
      bus_addr  = 2'($urandom);
      bus_wstrb = (($urandom % 4) == 0) ? 4'($urandom) : 4'h0;
      bus_wdata = $urandom;
      if (($urandom % 6) != 0) bus_wdata[3] = 1'b0;
      cyc();
    end
    rst = 1'b0; in_valid = 1'b0; bus_cs = 1'b0; bus_wstrb = 4'h0;
    repeat (4) cyc();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer between the `uart_rx` byte receiver and the picorv32 native memory bus. It captures every byte-valid pulse from the receiver into a DEPTH-entry FIFO, so the CPU can drain bursts at its own pace instead of racing the line rate. It exposes DATA, STATUS and CTRL registers in one chip-select window and drives a level IRQ line into the CPU IRQ bitmask, on the bit now used by the raw receiver done pulse.

## Interface
- `DEPTH`, 16: FIFO entries. Must be a power of two, 2..128.
- `clk` in 1: system clock (25 MHz).
- `rst` in 1: synchronous reset, active-high.
- `in_valid` in 1: one-cycle byte strobe from `uart_rx` (its done pulse).
- `in_data` in 8: received byte. Valid only when `in_valid` is high.
- `bus_cs` in 1: `mem_valid` ANDed with the address decode for this window.
- `bus_addr` in 2: word select, CPU address bits [3:2]. 0=DATA, 1=STATUS, 2=CTRL, 3=reserved.
- `bus_wstrb` in 4: byte write strobes. Zero means read.
- `bus_wdata` in 32: write data.
- `bus_rdata` out 32: registered read data. Valid while `bus_ready` is high.
- `bus_ready` out 1: single-cycle access acknowledge.
- `irq` out 1: level interrupt request.

## Operation
- **Storage:** DEPTH×8 array, write pointer, read pointer, `count` (width log2(DEPTH)+1). Pointers wrap modulo DEPTH.
- **Push:** on `in_valid`.
  - If `count < DEPTH`, or a pop happens in the same cycle, the byte is written.
  - Otherwise the byte is dropped and sticky `overflow` is set.
- **DATA read:**
  - FIFO non-empty: returns `{23'b0, 1'b0, head}` and pops one entry.
  - FIFO empty: returns `{23'b0, 1'b1, 8'h00}`. Bit 8 means "no data". No pop.
  - DATA writes are acknowledged and ignored.
- **STATUS read:** bit0 empty, bit1 full, bit2 overflow, bits[15:8] count, all other bits 0.
- **STATUS write, `wstrb[0]` set:**
  - `wdata[2]=1` clears `overflow` (write-1-to-clear).
  - `wdata[3]=1` flushes the FIFO: both pointers and count go to 0. A push in the same cycle is discarded.
- **CTRL, read/write:**
  - bit0 `rx_ie`, bit1 `ovf_ie`, bits[15:8] `thresh`.
  - `wstrb[0]` updates bits[7:0]; `wstrb[1]` updates bits[15:8]. Undefined bits read 0.
- **Reserved word:** reads 0, writes ignored, still acknowledged.
- **IRQ:** `irq = (rx_ie && count >= max(thresh,1)) || (ovf_ie && overflow)`, registered.
- **Simultaneous push and pop at `count == DEPTH`:** both happen, count stays DEPTH, no overflow.
- **Simultaneous push and pop at `count == 0`:** cannot occur; a pop at empty is not a pop. The push lands and count becomes 1.

## Timing
- **Handshake:** at a rising edge with `bus_cs=1` and `bus_ready=0`, the block captures `bus_rdata`, performs the write or pop, and sets `bus_ready=1`. `bus_ready` returns to 0 on the next edge regardless of `bus_cs`. Every access therefore costs 1 wait state and pops at most one entry, even if `bus_cs` is held.
- **Read data:** `bus_rdata` holds its value until the next access. It is sampled from pre-pop state, i.e. the head before this access.
- **STATUS/count coherence:** count, full and empty read by STATUS reflect state before any push in the same edge.
- **IRQ latency:** `irq` updates 1 cycle after the count, flag or CTRL change that causes it.
- **Push latency:** a byte pushed at edge N is readable by an access sampled at edge N+1.
- **Reset values:** `bus_rdata=0`, `bus_ready=0`, `irq=0`, `count=0`, both pointers 0, `overflow=0`, CTRL=`0x0000_0100` (thresh=1, IRQs off).
- **Reset mid-access:** `rst` overrides everything. `bus_ready` is 0 on the following cycle and no pop or write is retained.

## Test plan
- **Order:** reset, push 0x41, 0x42, 0x43 → STATUS reads `0x0000_0300`; three DATA reads return 0x41, 0x42, 0x43; fourth returns `0x0000_0100`; STATUS reads `0x0000_0001`.
- **Full/overflow:** DEPTH=16, push 17 bytes → STATUS `0x0000_1006`, 17th byte lost. Write STATUS `0x4` → overflow clears. Write `0x8` → STATUS `0x0000_0001`.
- **Push+pop at full:** 16 entries, `in_valid` on the same edge as a DATA read → count stays 16, overflow stays 0, head advances, new byte at tail.
- **IRQ threshold:** CTRL=`0x0000_0401`, push 3 bytes → `irq=0`. 4th push → `irq=1` one cycle later. One DATA read → `irq` drops.
- **Held chip select:** hold `bus_cs` high for 4 cycles on DATA with 3 entries → `bus_ready` pulses on cycles 1 and 3, exactly 2 pops, never 2 consecutive ready cycles.
- **Reset mid-access:** assert `rst` in the same cycle as `bus_cs` on DATA with 2 entries → next cycle `bus_ready=0`, `count=0`, `irq=0`, CTRL=`0x100`.
